// File: rtl/mmcm_lock_sequencer.sv
// MMCM lock sequencer: pulses the MMCM reset, waits for LOCKED with a timeout
// and bounded retries, then qualifies the generated clocks once lock has been
// continuously present for a settle window. Runs entirely on clkin1.
// Optional build macro: LOCK_LOSS_COUNT_EN adds a saturating lock-loss counter.
module mmcm_lock_sequencer #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 200000,
    parameter int SETTLE_CYCLES       = 1024,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_W               = 20,
    parameter int RETRY_W             = 2
) (
    input  logic               clkin1,
    input  logic               rst,
    input  logic               locked_in,
    input  logic               restart,
    output logic               mmcm_rst,
    output logic               clk_ready,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_count,
    output logic [2:0]         state_out
`ifdef LOCK_LOSS_COUNT_EN
    ,
    output logic [7:0]         lock_loss_count
`endif
);

    typedef enum logic [2:0] {
        ST_RESET_PULSE = 3'd0,
        ST_WAIT_LOCK   = 3'd1,
        ST_SETTLE      = 3'd2,
        ST_RUN         = 3'd3,
        ST_FAULT       = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [RETRY_W-1:0] retry_reg, retry_next;
    logic [1:0]         sync_reg;
    logic               locked_s;
    logic               mmcm_rst_reg, clk_ready_reg, fault_reg;

    assign locked_s = sync_reg[1];

    // Two-flop synchronizer for the asynchronous LOCKED signal
    always_ff @(posedge clkin1) begin
        if (rst) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], locked_in};
        end
    end

    // State, counter, retry and registered output flops
    always_ff @(posedge clkin1) begin
        if (rst) begin
            state_reg     <= ST_RESET_PULSE;
            cnt_reg       <= '0;
            retry_reg     <= '0;
            mmcm_rst_reg  <= 1'b1;
            clk_ready_reg <= 1'b0;
            fault_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            retry_reg     <= retry_next;
            mmcm_rst_reg  <= (state_next == ST_RESET_PULSE) || (state_next == ST_FAULT);
            clk_ready_reg <= (state_next == ST_RUN);
            fault_reg     <= (state_next == ST_FAULT);
        end
    end

    // Next-state logic; every state entry clears the counter so it never wraps
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + CNT_W'(1);
        retry_next = retry_reg;
        if (restart) begin
            state_next = ST_RESET_PULSE;
            cnt_next   = '0;
            retry_next = '0;
        end else begin
            case (state_reg)
                ST_RESET_PULSE: begin
                    if (cnt_reg == RST_LAST) begin
                        state_next = ST_WAIT_LOCK;
                        cnt_next   = '0;
                    end
                end
                ST_WAIT_LOCK: begin
                    // lock seen in the last timeout cycle still wins
                    if (locked_s) begin
                        state_next = ST_SETTLE;
                        cnt_next   = '0;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        cnt_next = '0;
                        if (retry_reg == RETRY_MAX) begin
                            state_next = ST_FAULT;
                        end else begin
                            state_next = ST_RESET_PULSE;
                            retry_next = retry_reg + RETRY_W'(1);
                        end
                    end
                end
                ST_SETTLE: begin
                    if (!locked_s) begin
                        state_next = ST_WAIT_LOCK;
                        cnt_next   = '0;
                    end else if (cnt_reg == SETTLE_LAST) begin
                        state_next = ST_RUN;
                        cnt_next   = '0;
                    end
                end
                ST_RUN: begin
                    cnt_next = cnt_reg;
                    if (!locked_s) begin
                        state_next = ST_RESET_PULSE;
                        cnt_next   = '0;
                        retry_next = '0;
                    end
                end
                ST_FAULT: begin
                    cnt_next = cnt_reg;
                end
                default: begin
                    state_next = ST_RESET_PULSE;
                    cnt_next   = '0;
                    retry_next = '0;
                end
            endcase
        end
    end

`ifdef LOCK_LOSS_COUNT_EN
    logic [7:0] loss_reg;
    logic       lock_lost;

    // a restart in the same cycle takes precedence, so it is not a lock loss
    assign lock_lost = !restart && (state_reg == ST_RUN) && !locked_s;

    // Saturating count of lock losses while running; only rst clears it
    always_ff @(posedge clkin1) begin
        if (rst) begin
            loss_reg <= 8'd0;
        end else if (lock_lost && (loss_reg != 8'hFF)) begin
            loss_reg <= loss_reg + 8'd1;
        end
    end

    assign lock_loss_count = loss_reg;
`endif

    assign mmcm_rst    = mmcm_rst_reg;
    assign clk_ready   = clk_ready_reg;
    assign fault       = fault_reg;
    assign retry_count = retry_reg;
    assign state_out   = state_reg;

endmodule

// File: tb/tb_mmcm_lock_sequencer.sv
// Testbench for mmcm_lock_sequencer: a table of hand-derived checkpoints,
// hand-written restart/timeout races, then random stimulus compared every
// cycle against a phase/age reference model.
module tb_mmcm_lock_sequencer;

    localparam int RSTP = 4;
    localparam int TO   = 20;
    localparam int SET  = 8;
    localparam int MAXR = 2;

    localparam int P_RST    = 0;
    localparam int P_WAIT   = 1;
    localparam int P_SETTLE = 2;
    localparam int P_RUN    = 3;
    localparam int P_FAULT  = 4;

    logic       clkin1 = 1'b0;
    logic       rst = 1'b1;
    logic       locked_in = 1'b0;
    logic       restart = 1'b0;
    logic       mmcm_rst, clk_ready, fault;
    logic [1:0] retry_count;
    logic [2:0] state_out;
`ifdef LOCK_LOSS_COUNT_EN
    logic [7:0] lock_loss_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    // reference model: phase, cycles spent in phase, lock history
    int m_phase = 0;
    int m_age = 0;
    int m_retry = 0;
    int m_llc = 0;
    bit m_s1 = 1'b0;
    bit m_s2 = 1'b0;

    always #5 clkin1 = ~clkin1;

    mmcm_lock_sequencer #(
        .RST_PULSE_CYCLES(RSTP),
        .LOCK_TIMEOUT_CYCLES(TO),
        .SETTLE_CYCLES(SET),
        .MAX_RETRIES(MAXR),
        .CNT_W(8),
        .RETRY_W(2)
    ) dut (
        .clkin1(clkin1),
        .rst(rst),
        .locked_in(locked_in),
        .restart(restart),
        .mmcm_rst(mmcm_rst),
        .clk_ready(clk_ready),
        .fault(fault),
        .retry_count(retry_count),
        .state_out(state_out)
`ifdef LOCK_LOSS_COUNT_EN
        ,
        .lock_loss_count(lock_loss_count)
`endif
    );

    typedef struct {
        bit r;
        bit lin;
        bit rs;
        int cycles;
        int st;
        bit mr;
        bit rdy;
        bit flt;
        int rc;
    } vec_t;

    vec_t tbl [0:35];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // advance the model by one rising edge using the inputs present at that edge
    task automatic model_edge(input bit r, input bit lin, input bit rs);
        bit ls;
        bit fresh;
        int nxt;
        ls = m_s2;
        if (r) begin
            m_phase = P_RST; m_age = 0; m_retry = 0; m_llc = 0;
            m_s1 = 1'b0; m_s2 = 1'b0;
            return;
        end
        m_s2 = m_s1;
        m_s1 = lin;
        nxt = m_phase;
        fresh = 1'b0;
        if (rs) begin
            nxt = P_RST; m_retry = 0; fresh = 1'b1;
        end else if (m_phase == P_RST) begin
            if (m_age == RSTP - 1) begin nxt = P_WAIT; fresh = 1'b1; end
        end else if (m_phase == P_WAIT) begin
            if (ls) begin
                nxt = P_SETTLE; fresh = 1'b1;
            end else if (m_age == TO - 1) begin
                fresh = 1'b1;
                if (m_retry == MAXR) nxt = P_FAULT;
                else begin nxt = P_RST; m_retry = m_retry + 1; end
            end
        end else if (m_phase == P_SETTLE) begin
            if (!ls) begin nxt = P_WAIT; fresh = 1'b1; end
            else if (m_age == SET - 1) begin nxt = P_RUN; fresh = 1'b1; end
        end else if (m_phase == P_RUN) begin
            if (!ls) begin
                nxt = P_RST; m_retry = 0; fresh = 1'b1;
                if (m_llc < 255) m_llc = m_llc + 1;
            end
        end
        m_phase = nxt;
        m_age = fresh ? 0 : m_age + 1;
    endtask

    task automatic compare_model();
        check("state", 32'(state_out), 32'(m_phase));
        check("mmcm_rst", 32'(mmcm_rst), 32'((m_phase == P_RST) || (m_phase == P_FAULT)));
        check("clk_ready", 32'(clk_ready), 32'(m_phase == P_RUN));
        check("fault", 32'(fault), 32'(m_phase == P_FAULT));
        check("retry_count", 32'(retry_count), 32'(m_retry));
`ifdef LOCK_LOSS_COUNT_EN
        check("lock_loss_count", 32'(lock_loss_count), 32'(m_llc));
`endif
    endtask

    task automatic tick();
        @(posedge clkin1);
        model_edge(rst, locked_in, restart);
        #1;
        compare_model();
    endtask

    task automatic expect_out(input string tag, input int st, input bit mr, input bit rdy,
                              input bit flt, input int rc);
        check({tag, "_state"}, 32'(state_out), 32'(st));
        check({tag, "_mmcm_rst"}, 32'(mmcm_rst), 32'(mr));
        check({tag, "_clk_ready"}, 32'(clk_ready), 32'(rdy));
        check({tag, "_fault"}, 32'(fault), 32'(flt));
        check({tag, "_retry"}, 32'(retry_count), 32'(rc));
    endtask

    initial begin
        // normal lock, lock loss, total timeout, restart, settle glitch, rst mid-settle
        tbl[0]  = '{1, 0, 0,   2, 0, 1, 0, 0, 0};
        tbl[1]  = '{0, 0, 0,   3, 0, 1, 0, 0, 0};
        tbl[2]  = '{0, 0, 0,   1, 1, 0, 0, 0, 0};
        tbl[3]  = '{0, 1, 0,   2, 1, 0, 0, 0, 0};
        tbl[4]  = '{0, 1, 0,   1, 2, 0, 0, 0, 0};
        tbl[5]  = '{0, 1, 0,   7, 2, 0, 0, 0, 0};
        tbl[6]  = '{0, 1, 0,   1, 3, 0, 1, 0, 0};
        tbl[7]  = '{0, 0, 0,   2, 3, 0, 1, 0, 0};
        tbl[8]  = '{0, 0, 0,   1, 0, 1, 0, 0, 0};
        tbl[9]  = '{0, 0, 0,   3, 0, 1, 0, 0, 0};
        tbl[10] = '{0, 0, 0,   1, 1, 0, 0, 0, 0};
        tbl[11] = '{0, 0, 0,  19, 1, 0, 0, 0, 0};
        tbl[12] = '{0, 0, 0,   1, 0, 1, 0, 0, 1};
        tbl[13] = '{0, 0, 0,  23, 1, 0, 0, 0, 1};
        tbl[14] = '{0, 0, 0,   1, 0, 1, 0, 0, 2};
        tbl[15] = '{0, 0, 0,  23, 1, 0, 0, 0, 2};
        tbl[16] = '{0, 0, 0,   1, 4, 1, 0, 1, 2};
        tbl[17] = '{0, 0, 0, 200, 4, 1, 0, 1, 2};
        tbl[18] = '{0, 0, 1,   1, 0, 1, 0, 0, 0};
        tbl[19] = '{0, 1, 0,   4, 1, 0, 0, 0, 0};
        tbl[20] = '{0, 1, 0,   1, 2, 0, 0, 0, 0};
        tbl[21] = '{0, 1, 0,   4, 2, 0, 0, 0, 0};
        tbl[22] = '{0, 0, 0,   1, 2, 0, 0, 0, 0};
        tbl[23] = '{0, 1, 0,   1, 2, 0, 0, 0, 0};
        tbl[24] = '{0, 1, 0,   1, 1, 0, 0, 0, 0};
        tbl[25] = '{0, 1, 0,   1, 2, 0, 0, 0, 0};
        tbl[26] = '{0, 1, 0,   7, 2, 0, 0, 0, 0};
        tbl[27] = '{0, 1, 0,   1, 3, 0, 1, 0, 0};
        tbl[28] = '{0, 1, 1,   1, 0, 1, 0, 0, 0};
        tbl[29] = '{0, 1, 0,   4, 1, 0, 0, 0, 0};
        tbl[30] = '{0, 1, 0,   3, 2, 0, 0, 0, 0};
        tbl[31] = '{1, 1, 0,   1, 0, 1, 0, 0, 0};
        tbl[32] = '{0, 1, 0,   3, 0, 1, 0, 0, 0};
        tbl[33] = '{0, 1, 0,   1, 1, 0, 0, 0, 0};
        tbl[34] = '{0, 1, 0,   1, 2, 0, 0, 0, 0};
        tbl[35] = '{0, 1, 0,   8, 3, 0, 1, 0, 0};

        for (int i = 0; i < 36; i++) begin
            rst = tbl[i].r;
            locked_in = tbl[i].lin;
            restart = tbl[i].rs;
            for (int c = 0; c < tbl[i].cycles; c++) tick();
            expect_out($sformatf("row%0d", i), tbl[i].st, tbl[i].mr, tbl[i].rdy,
                       tbl[i].flt, tbl[i].rc);
        end
`ifdef LOCK_LOSS_COUNT_EN
        check("llc_after_table", 32'(lock_loss_count), 32'd1);
`endif

        // restart coinciding with the first timeout edge
        restart = 1'b0; locked_in = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 23; c++) tick();
        expect_out("pre_timeout", 1, 0, 0, 0, 0);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        expect_out("restart_vs_timeout", 0, 1, 0, 0, 0);

        // restart coinciding with the edge that would enter FAULT
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 71; c++) tick();
        expect_out("pre_fault", 1, 0, 0, 0, 2);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        expect_out("restart_vs_fault", 0, 1, 0, 0, 0);

        // random stimulus with long lock runs so every phase is reached
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 39) == 0) locked_in = ~locked_in;
            restart = ($urandom_range(0, 299) == 0);
            rst = ($urandom_range(0, 799) == 0);
            tick();
        end
        rst = 1'b0; restart = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
